// File: rtl/ht_chain_delete_engine.sv
// ht_chain_delete_engine
//   Walks one hash bucket's singly linked chain in the data RAM, unlinks
//   entries whose key matches, zeroes and frees their slots, then reports a
//   result code and the number of entries freed.
//   task_all_i selects "first match only" (0) or "every match" (1).
//   A hop counter aborts with CHAIN_ERR once MAX_CHAIN nodes have been read,
//   which protects against cyclic (corrupted) chains.
//
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   task_*                delete command (valid/ready handshake)
//   rd_*                  data-RAM read port, data arrives RAM_LATENCY cycles
//                         after rd_en_o
//   wr_*                  data-RAM write port (unlink rewrite, slot zeroing)
//   head_wr_*             head-table update when the bucket's first node goes
//   free_ptr_*            slot returned to the empty list
//   res_*                 result (valid/ready handshake), code 0 SUCCESS,
//                         1 NO_ENTRY, 2 CHAIN_ERR
module ht_chain_delete_engine #(
    parameter int KEY_WIDTH    = 32,
    parameter int VALUE_WIDTH  = 32,
    parameter int A_WIDTH      = 10,
    parameter int BUCKET_WIDTH = 8,
    parameter int RAM_LATENCY  = 2,
    parameter int MAX_CHAIN    = 64,
    parameter int CNT_W        = $clog2(MAX_CHAIN + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [KEY_WIDTH-1:0]    task_key_i,
    input  logic [BUCKET_WIDTH-1:0] task_bucket_i,
    input  logic [A_WIDTH-1:0]      task_head_ptr_i,
    input  logic                    task_head_val_i,
    input  logic                    task_all_i,
    input  logic                    task_valid_i,
    output logic                    task_ready_o,
    output logic [A_WIDTH-1:0]      rd_addr_o,
    output logic                    rd_en_o,
    input  logic [KEY_WIDTH-1:0]    rd_key_i,
    input  logic [VALUE_WIDTH-1:0]  rd_value_i,
    input  logic [A_WIDTH-1:0]      rd_next_ptr_i,
    input  logic                    rd_next_val_i,
    output logic [A_WIDTH-1:0]      wr_addr_o,
    output logic [KEY_WIDTH-1:0]    wr_key_o,
    output logic [VALUE_WIDTH-1:0]  wr_value_o,
    output logic [A_WIDTH-1:0]      wr_next_ptr_o,
    output logic                    wr_next_val_o,
    output logic                    wr_en_o,
    output logic                    head_wr_en_o,
    output logic [BUCKET_WIDTH-1:0] head_wr_bucket_o,
    output logic [A_WIDTH-1:0]      head_wr_ptr_o,
    output logic                    head_wr_ptr_val_o,
    output logic [A_WIDTH-1:0]      free_ptr_o,
    output logic                    free_ptr_en_o,
    output logic [KEY_WIDTH-1:0]    res_key_o,
    output logic [1:0]              res_code_o,
    output logic [CNT_W-1:0]        res_count_o,
    output logic                    res_valid_o,
    input  logic                    res_ready_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_UNLINK,
        ST_FREE,
        ST_RESULT
    } state_t;

    localparam logic [1:0]       CODE_SUCCESS   = 2'd0;
    localparam logic [1:0]       CODE_NO_ENTRY  = 2'd1;
    localparam logic [1:0]       CODE_CHAIN_ERR = 2'd2;
    localparam logic [CNT_W-1:0] HOPS_MAX       = CNT_W'(MAX_CHAIN);

    state_t                  state_reg, state_next;
    logic                    ready_en_reg;
    logic [KEY_WIDTH-1:0]    key_reg, key_next;
    logic [BUCKET_WIDTH-1:0] bucket_reg, bucket_next;
    logic                    all_reg, all_next;
    logic [A_WIDTH-1:0]      cur_reg, cur_next;
    logic [A_WIDTH-1:0]      prev_reg, prev_next;
    logic                    prev_val_reg, prev_val_next;
    logic [KEY_WIDTH-1:0]    prev_key_reg, prev_key_next;
    logic [VALUE_WIDTH-1:0]  prev_value_reg, prev_value_next;
    logic [A_WIDTH-1:0]      prev_nptr_reg, prev_nptr_next;
    logic                    prev_nval_reg, prev_nval_next;
    logic [A_WIDTH-1:0]      cur_nptr_reg, cur_nptr_next;
    logic                    cur_nval_reg, cur_nval_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic [CNT_W-1:0]        hops_reg, hops_next;
    logic [1:0]              code_reg, code_next;
    logic [RAM_LATENCY-1:0]  vpipe_reg;
    logic                    data_valid;

    // One bit per cycle of read latency; the top bit marks the data cycle.
    assign data_valid = vpipe_reg[RAM_LATENCY-1];

    assign res_key_o   = key_reg;
    assign res_code_o  = code_reg;
    assign res_count_o = count_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vpipe_reg <= '0;
        end else begin
            vpipe_reg[0] <= rd_en_o;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vpipe_reg[i] <= vpipe_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg      <= ST_IDLE;
            ready_en_reg   <= 1'b0;
            key_reg        <= '0;
            bucket_reg     <= '0;
            all_reg        <= 1'b0;
            cur_reg        <= '0;
            prev_reg       <= '0;
            prev_val_reg   <= 1'b0;
            prev_key_reg   <= '0;
            prev_value_reg <= '0;
            prev_nptr_reg  <= '0;
            prev_nval_reg  <= 1'b0;
            cur_nptr_reg   <= '0;
            cur_nval_reg   <= 1'b0;
            count_reg      <= '0;
            hops_reg       <= '0;
            code_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            ready_en_reg   <= 1'b1;  // keeps ready low until the first edge after release
            key_reg        <= key_next;
            bucket_reg     <= bucket_next;
            all_reg        <= all_next;
            cur_reg        <= cur_next;
            prev_reg       <= prev_next;
            prev_val_reg   <= prev_val_next;
            prev_key_reg   <= prev_key_next;
            prev_value_reg <= prev_value_next;
            prev_nptr_reg  <= prev_nptr_next;
            prev_nval_reg  <= prev_nval_next;
            cur_nptr_reg   <= cur_nptr_next;
            cur_nval_reg   <= cur_nval_next;
            count_reg      <= count_next;
            hops_reg       <= hops_next;
            code_reg       <= code_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        key_next          = key_reg;
        bucket_next       = bucket_reg;
        all_next          = all_reg;
        cur_next          = cur_reg;
        prev_next         = prev_reg;
        prev_val_next     = prev_val_reg;
        prev_key_next     = prev_key_reg;
        prev_value_next   = prev_value_reg;
        prev_nptr_next    = prev_nptr_reg;
        prev_nval_next    = prev_nval_reg;
        cur_nptr_next     = cur_nptr_reg;
        cur_nval_next     = cur_nval_reg;
        count_next        = count_reg;
        hops_next         = hops_reg;
        code_next         = code_reg;
        task_ready_o      = 1'b0;
        rd_en_o           = 1'b0;
        rd_addr_o         = '0;
        wr_en_o           = 1'b0;
        wr_addr_o         = '0;
        wr_key_o          = '0;
        wr_value_o        = '0;
        wr_next_ptr_o     = '0;
        wr_next_val_o     = 1'b0;
        head_wr_en_o      = 1'b0;
        head_wr_bucket_o  = '0;
        head_wr_ptr_o     = '0;
        head_wr_ptr_val_o = 1'b0;
        free_ptr_en_o     = 1'b0;
        free_ptr_o        = '0;
        res_valid_o       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                task_ready_o = ready_en_reg;
                if (task_valid_i && ready_en_reg) begin
                    key_next      = task_key_i;
                    bucket_next   = task_bucket_i;
                    all_next      = task_all_i;
                    count_next    = '0;
                    hops_next     = '0;
                    prev_val_next = 1'b0;
                    if (!task_head_val_i) begin
                        code_next  = CODE_NO_ENTRY;
                        state_next = ST_RESULT;
                    end else begin
                        cur_next   = task_head_ptr_i;
                        state_next = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                rd_en_o    = 1'b1;
                rd_addr_o  = cur_reg;
                hops_next  = hops_reg + CNT_W'(1);
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (data_valid) begin
                    cur_nptr_next = rd_next_ptr_i;
                    cur_nval_next = rd_next_val_i;
                    if (rd_key_i == key_reg) begin
                        state_next = ST_UNLINK;
                    end else if (rd_next_val_i) begin
                        if (hops_reg == HOPS_MAX) begin
                            code_next  = CODE_CHAIN_ERR;
                            state_next = ST_RESULT;
                        end else begin
                            prev_next       = cur_reg;
                            prev_val_next   = 1'b1;
                            prev_key_next   = rd_key_i;
                            prev_value_next = rd_value_i;
                            prev_nptr_next  = rd_next_ptr_i;
                            prev_nval_next  = rd_next_val_i;
                            cur_next        = rd_next_ptr_i;
                            state_next      = ST_RD_ISSUE;
                        end
                    end else begin
                        code_next  = (count_reg != '0) ? CODE_SUCCESS : CODE_NO_ENTRY;
                        state_next = ST_RESULT;
                    end
                end
            end
            ST_UNLINK: begin
                if (!prev_val_reg) begin
                    head_wr_en_o      = 1'b1;
                    head_wr_bucket_o  = bucket_reg;
                    head_wr_ptr_o     = cur_nptr_reg;
                    head_wr_ptr_val_o = cur_nval_reg;
                end else begin
                    // Predecessor now skips the victim; keep our copy coherent
                    // so a later unlink in all-mode rewrites the right word.
                    wr_en_o        = 1'b1;
                    wr_addr_o      = prev_reg;
                    wr_key_o       = prev_key_reg;
                    wr_value_o     = prev_value_reg;
                    wr_next_ptr_o  = cur_nptr_reg;
                    wr_next_val_o  = cur_nval_reg;
                    prev_nptr_next = cur_nptr_reg;
                    prev_nval_next = cur_nval_reg;
                end
                state_next = ST_FREE;
            end
            ST_FREE: begin
                wr_en_o       = 1'b1;
                wr_addr_o     = cur_reg;
                free_ptr_en_o = 1'b1;
                free_ptr_o    = cur_reg;
                count_next    = count_reg + CNT_W'(1);
                if (all_reg && cur_nval_reg) begin
                    if (hops_reg == HOPS_MAX) begin
                        code_next  = CODE_CHAIN_ERR;
                        state_next = ST_RESULT;
                    end else begin
                        cur_next   = cur_nptr_reg;  // predecessor is unchanged
                        state_next = ST_RD_ISSUE;
                    end
                end else begin
                    code_next  = CODE_SUCCESS;
                    state_next = ST_RESULT;
                end
            end
            ST_RESULT: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ht_chain_delete_engine.sv
module tb_ht_chain_delete_engine;
    localparam int KW = 16, VW = 16, AW = 4, BW = 3, LAT = 2, MC = 4;
    localparam int CW = $clog2(MC + 1);
    localparam int DEPTH = 1 << AW;
    localparam int NB = 1 << BW;

    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] value;
        logic [AW-1:0] nptr;
        logic          nval;
    } word_t;
    typedef struct packed { logic [AW-1:0] addr; word_t w; } wr_t;
    typedef struct packed { logic [BW-1:0] bucket; logic [AW-1:0] ptr; logic val; } hd_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [KW-1:0] task_key = '0;
    logic [BW-1:0] task_bucket = '0;
    logic [AW-1:0] task_head_ptr = '0;
    logic task_head_val = 1'b0, task_all = 1'b0, task_valid = 1'b0, task_ready;
    logic [AW-1:0] rd_addr; logic rd_en;
    logic [KW-1:0] rd_key = '0; logic [VW-1:0] rd_value = '0;
    logic [AW-1:0] rd_next_ptr = '0; logic rd_next_val = 1'b0;
    logic [AW-1:0] wr_addr, wr_next_ptr; logic [KW-1:0] wr_key; logic [VW-1:0] wr_value;
    logic wr_next_val, wr_en, head_wr_en, head_wr_ptr_val, free_ptr_en, res_valid;
    logic [BW-1:0] head_wr_bucket; logic [AW-1:0] head_wr_ptr, free_ptr;
    logic [KW-1:0] res_key; logic [1:0] res_code; logic [CW-1:0] res_count;
    logic res_ready = 1'b0;

    always #5 clk = ~clk;

    ht_chain_delete_engine #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .A_WIDTH(AW), .BUCKET_WIDTH(BW),
                             .RAM_LATENCY(LAT), .MAX_CHAIN(MC)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .task_key_i(task_key), .task_bucket_i(task_bucket), .task_head_ptr_i(task_head_ptr),
        .task_head_val_i(task_head_val), .task_all_i(task_all),
        .task_valid_i(task_valid), .task_ready_o(task_ready),
        .rd_addr_o(rd_addr), .rd_en_o(rd_en),
        .rd_key_i(rd_key), .rd_value_i(rd_value), .rd_next_ptr_i(rd_next_ptr), .rd_next_val_i(rd_next_val),
        .wr_addr_o(wr_addr), .wr_key_o(wr_key), .wr_value_o(wr_value), .wr_next_ptr_o(wr_next_ptr),
        .wr_next_val_o(wr_next_val), .wr_en_o(wr_en),
        .head_wr_en_o(head_wr_en), .head_wr_bucket_o(head_wr_bucket), .head_wr_ptr_o(head_wr_ptr),
        .head_wr_ptr_val_o(head_wr_ptr_val),
        .free_ptr_o(free_ptr), .free_ptr_en_o(free_ptr_en),
        .res_key_o(res_key), .res_code_o(res_code), .res_count_o(res_count),
        .res_valid_o(res_valid), .res_ready_i(res_ready)
    );

    // RAM / head table as seen by the world, and the model's predicted image
    word_t mem [DEPTH];
    word_t m_mem [DEPTH];
    logic [AW-1:0] head_ptr [NB];
    logic head_val [NB];
    logic [AW-1:0] m_hptr [NB];
    logic m_hval [NB];

    logic [AW-1:0] exp_rd [$];
    wr_t exp_wr [$];
    hd_t exp_hd [$];
    logic [AW-1:0] exp_fr [$];
    int exp_code, exp_count, exp_lat;
    logic [KW-1:0] exp_key;

    int checks = 0, errors = 0;
    int cyc = 0, accept_cyc = 0, n_reads = 0, n_strobes = 0;
    int last_code = -1, last_count = -1, last_lat = -1;
    logic [AW-1:0] last_free = '0;
    bit res_seen = 1'b0;
    logic [KW+2+CW-1:0] res_hold = '0;
    bit pend_v = 1'b0;
    int pend_due = 0;
    logic [AW-1:0] pend_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got strobe with %0h, expected none", name, act);
    endtask

    // Compare process + RAM model, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs_zero",
                  {63'd0, |{task_ready, rd_addr, rd_en, wr_addr, wr_key, wr_value, wr_next_ptr, wr_next_val,
                            wr_en, head_wr_en, head_wr_bucket, head_wr_ptr, head_wr_ptr_val, free_ptr,
                            free_ptr_en, res_key, res_code, res_count, res_valid}}, 64'd0);
            pend_v = 1'b0;
        end else begin
            cyc++;
            check("rd_overlaps_write", {63'd0, rd_en & (wr_en | head_wr_en | free_ptr_en)}, 64'd0);
            if (task_valid && task_ready) begin
                accept_cyc = cyc;
                res_seen = 1'b0;
            end
            if (rd_en) begin
                n_reads++;
                if (exp_rd.size() == 0) unexpected("rd_unexpected", {60'd0, rd_addr});
                else check("rd_addr", {60'd0, rd_addr}, {60'd0, exp_rd.pop_front()});
                pend_v = 1'b1; pend_due = cyc + LAT; pend_addr = rd_addr;
            end
            if (wr_en) begin
                wr_t w;
                n_strobes++;
                w.addr = wr_addr;
                w.w = '{key: wr_key, value: wr_value, nptr: wr_next_ptr, nval: wr_next_val};
                if (exp_wr.size() == 0) unexpected("wr_unexpected", {23'd0, w});
                else check("wr_word", {23'd0, w}, {23'd0, exp_wr.pop_front()});
                mem[wr_addr] = w.w;
            end
            if (head_wr_en) begin
                hd_t h;
                n_strobes++;
                h = '{bucket: head_wr_bucket, ptr: head_wr_ptr, val: head_wr_ptr_val};
                if (exp_hd.size() == 0) unexpected("head_unexpected", {56'd0, h});
                else check("head_write", {56'd0, h}, {56'd0, exp_hd.pop_front()});
                head_ptr[head_wr_bucket] = head_wr_ptr;
                head_val[head_wr_bucket] = head_wr_ptr_val;
            end
            if (free_ptr_en) begin
                n_strobes++;
                last_free = free_ptr;
                if (exp_fr.size() == 0) unexpected("free_unexpected", {60'd0, free_ptr});
                else check("free_ptr", {60'd0, free_ptr}, {60'd0, exp_fr.pop_front()});
            end
            if (res_valid) begin
                if (!res_seen) begin
                    res_seen = 1'b1;
                    last_code = int'(res_code); last_count = int'(res_count); last_lat = cyc - accept_cyc;
                    check("res_code", {62'd0, res_code}, exp_code);
                    check("res_count", {61'd0, res_count}, exp_count);
                    check("res_key", {48'd0, res_key}, {48'd0, exp_key});
                    check("res_latency", last_lat, exp_lat);
                    res_hold = {res_key, res_code, res_count};
                end else begin
                    check("res_stable", {43'd0, res_key, res_code, res_count}, {43'd0, res_hold});
                end
            end
            if (pend_v && pend_due == cyc) begin
                pend_v = 1'b0;
                {rd_key, rd_value, rd_next_ptr, rd_next_val} = mem[pend_addr];
            end else begin
                // garbage outside the data cycle catches early/late sampling
                rd_key = KW'($urandom); rd_value = VW'($urandom);
                rd_next_ptr = AW'($urandom); rd_next_val = 1'($urandom);
            end
        end
    end

    // Reference: walk the chain on a copy of the RAM and list every effect.
    task automatic run_model(input logic [KW-1:0] key, input int bucket, input bit all);
        logic [AW-1:0] cur, prev;
        bit pv, done;
        int visits, cnt;
        word_t w;
        wr_t e;
        hd_t h;
        m_mem = mem;
        for (int b = 0; b < NB; b++) begin m_hptr[b] = head_ptr[b]; m_hval[b] = head_val[b]; end
        exp_rd.delete(); exp_wr.delete(); exp_hd.delete(); exp_fr.delete();
        exp_key = key; visits = 0; cnt = 0; pv = 0; prev = '0; done = 0;
        cur = head_ptr[bucket];
        exp_code = 1;
        if (head_val[bucket]) begin
            while (!done) begin
                visits++;
                exp_rd.push_back(cur);
                w = m_mem[cur];
                if (w.key == key) begin
                    if (!pv) begin
                        h = '{bucket: BW'(bucket), ptr: w.nptr, val: w.nval};
                        exp_hd.push_back(h);
                        m_hptr[bucket] = w.nptr; m_hval[bucket] = w.nval;
                    end else begin
                        m_mem[prev].nptr = w.nptr; m_mem[prev].nval = w.nval;
                        e = '{addr: prev, w: m_mem[prev]};
                        exp_wr.push_back(e);
                    end
                    m_mem[cur] = '0;
                    e = '{addr: cur, w: '0};
                    exp_wr.push_back(e);
                    exp_fr.push_back(cur);
                    cnt++;
                    if (all && w.nval) begin
                        if (visits == MC) begin exp_code = 2; done = 1; end
                        else cur = w.nptr;
                    end else begin
                        exp_code = 0; done = 1;
                    end
                end else if (w.nval) begin
                    if (visits == MC) begin exp_code = 2; done = 1; end
                    else begin prev = cur; pv = 1; cur = w.nptr; end
                end else begin
                    exp_code = (cnt > 0) ? 0 : 1; done = 1;
                end
            end
        end
        exp_count = cnt;
        exp_lat = visits * (1 + LAT) + 2 * cnt + 1;
    endtask

    task automatic run_task(input logic [KW-1:0] key, input int bucket, input bit all, input int hold);
        int n;
        run_model(key, bucket, all);
        task_key = key; task_bucket = BW'(bucket); task_all = all;
        task_head_ptr = head_ptr[bucket]; task_head_val = head_val[bucket];
        task_valid = 1'b1;
        n = 0;
        while (!task_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("accept_timeout", {63'd0, task_ready}, 64'd1);
        @(posedge clk); #1;
        task_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 300) begin @(posedge clk); #1; n++; end
        check("result_timeout", {63'd0, res_valid}, 64'd1);
        repeat (hold) begin
            check("ready_low_in_result", {63'd0, task_ready}, 64'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("rd_all_issued", exp_rd.size(), 0);
        check("wr_all_issued", exp_wr.size(), 0);
        check("head_all_issued", exp_hd.size(), 0);
        check("free_all_issued", exp_fr.size(), 0);
        for (int a = 0; a < DEPTH; a++) check("ram_image", {27'd0, mem[a]}, {27'd0, m_mem[a]});
        for (int b = 0; b < NB; b++) check("head_image", {head_val[b], head_ptr[b]}, {m_hval[b], m_hptr[b]});
        $display("task key=%h bucket=%0d all=%0d -> code=%0d count=%0d latency=%0d",
                 key, bucket, all, last_code, last_count, last_lat);
    endtask

    task automatic set_node(input int a, input logic [KW-1:0] k, input int nx, input bit nv);
        mem[a] = '{key: k, value: VW'($urandom), nptr: AW'(nx), nval: nv};
    endtask

    task automatic setup_abc(input int b);
        set_node(5, 16'h000A, 9, 1); set_node(9, 16'h000B, 3, 1); set_node(3, 16'h000C, 0, 0);
        head_ptr[b] = 4'd5; head_val[b] = 1'b1;
    endtask

    initial begin
        int s0, r0, perm [DEPTH];
        for (int a = 0; a < DEPTH; a++) mem[a] = word_t'({$urandom, $urandom});
        for (int b = 0; b < NB; b++) begin head_ptr[b] = AW'($urandom); head_val[b] = 1'b0; end

        // reset: outputs are zero, ready rises only after an edge post-release
        repeat (3) @(posedge clk);
        #1 check("ready_in_reset", {63'd0, task_ready}, 64'd0);
        rst_n = 1'b1;
        #1 check("ready_before_edge", {63'd0, task_ready}, 64'd0);
        @(posedge clk); #1;
        check("ready_after_release", {63'd0, task_ready}, 64'd1);

        // no head
        s0 = n_strobes; r0 = n_reads; head_val[1] = 1'b0;
        run_task(16'h0011, 1, 0, 0);
        check("t1_code", last_code, 1); check("t1_count", last_count, 0);
        check("t1_latency", last_lat, 1); check("t1_strobes", n_strobes - s0 + n_reads - r0, 0);

        // delete middle B
        setup_abc(2);
        run_task(16'h000B, 2, 0, 0);
        check("t2_link", {mem[5].nval, mem[5].nptr}, {1'b1, 4'd3});
        check("t2_zero", {27'd0, mem[9]}, 64'd0);
        check("t2_free", {60'd0, last_free}, 64'd9);
        check("t2_code", last_code, 0); check("t2_count", last_count, 1); check("t2_latency", last_lat, 9);

        // delete head A, then tail C
        setup_abc(2);
        run_task(16'h000A, 2, 0, 0);
        check("t3_head", {head_val[2], head_ptr[2]}, {1'b1, 4'd9});
        check("t3_free", {60'd0, last_free}, 64'd5);
        setup_abc(2);
        run_task(16'h000C, 2, 0, 0);
        check("t3_tail_nval", {63'd0, mem[9].nval}, 64'd0);
        check("t3_tail_free", {60'd0, last_free}, 64'd3);
        check("t3_tail_latency", last_lat, 12);

        // delete all K in 4->7->2 (K,X,K)
        set_node(4, 16'h0021, 7, 1); set_node(7, 16'h0022, 2, 1); set_node(2, 16'h0021, 0, 0);
        head_ptr[3] = 4'd4; head_val[3] = 1'b1;
        run_task(16'h0021, 3, 1, 0);
        check("t4_head", {head_val[3], head_ptr[3]}, {1'b1, 4'd7});
        check("t4_tail_nval", {63'd0, mem[7].nval}, 64'd0);
        check("t4_code", last_code, 0); check("t4_count", last_count, 2); check("t4_latency", last_lat, 14);

        // cyclic 1->2->1 without match, held result for 10 cycles
        set_node(1, 16'h0031, 2, 1); set_node(2, 16'h0032, 1, 1);
        head_ptr[4] = 4'd1; head_val[4] = 1'b1;
        r0 = n_reads;
        run_task(16'h0039, 4, 0, 10);
        check("t5_reads", n_reads - r0, 4);
        check("t5_code", last_code, 2); check("t5_count", last_count, 0);

        // reset mid-walk
        setup_abc(5);
        run_model(16'h0077, 5, 0);
        task_key = 16'h0077; task_bucket = 3'd5; task_head_ptr = 4'd5; task_head_val = 1'b1;
        task_all = 1'b0; task_valid = 1'b1;
        @(posedge clk); #1; task_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check("midreset_strobes", {60'd0, rd_en, wr_en, head_wr_en, free_ptr_en}, 64'd0);
        check("midreset_ready", {63'd0, task_ready}, 64'd0);
        exp_rd.delete(); exp_wr.delete(); exp_hd.delete(); exp_fr.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset_ready_after", {63'd0, task_ready}, 64'd1);
        $display("task reset mid-walk -> aborted");

        // randomized chains
        for (int t = 0; t < 40; t++) begin
            int n, b, j, tmp;
            for (int a = 0; a < DEPTH; a++) perm[a] = a;
            for (int a = DEPTH - 1; a > 0; a--) begin
                j = $urandom_range(0, a); tmp = perm[a]; perm[a] = perm[j]; perm[j] = tmp;
            end
            n = $urandom_range(1, 6);
            b = $urandom_range(0, NB - 1);
            for (int i = 0; i < n; i++) begin
                if (i < n - 1) set_node(perm[i], KW'($urandom_range(1, 3)), perm[i+1], 1);
                else if ($urandom_range(0, 4) == 0)
                    set_node(perm[i], KW'($urandom_range(1, 3)), perm[$urandom_range(0, i)], 1);
                else set_node(perm[i], KW'($urandom_range(1, 3)), $urandom_range(0, DEPTH - 1), 0);
            end
            head_ptr[b] = AW'(perm[0]);
            head_val[b] = ($urandom_range(0, 9) != 0);
            run_task(KW'($urandom_range(1, 3)), b, 1'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/ht_chain_delete_engine.md
# ht_chain_delete_engine

Parametrised delete engine for the hash-table data RAM: walks a bucket's singly linked chain, unlinks matching entries, zeroes and frees their slots, and reports a result. It replaces the fixed-width single-match delete FSM. It adds generic key/value widths, a per-task mode that deletes either the first match or every match, a deleted-entry count, and a chain-length guard against corrupted (cyclic) chains. It sits between the command dispatcher and the shared data RAM, head table and empty-pointer storage.

## Interface
- KEY_WIDTH, 32, key bits
- VALUE_WIDTH, 32, value bits
- A_WIDTH, 10, data-RAM address bits
- BUCKET_WIDTH, 8, head-table index bits
- RAM_LATENCY, 2, read latency, rd_en to data valid, ≥1
- MAX_CHAIN, 64, maximum nodes visited per task before abort
- CNT_W = $clog2(MAX_CHAIN+1), derived
- clk_i  in  1  single clock; all logic is on posedge
- rst_n_i  in  1  asynchronous, active-low reset
- task_key_i / task_bucket_i / task_head_ptr_i / task_head_val_i / task_all_i  in  KEY_WIDTH/BUCKET_WIDTH/A_WIDTH/1/1  delete command; task_all_i=1 deletes all matches
- task_valid_i in 1, task_ready_o out 1  command handshake
- rd_addr_o out A_WIDTH, rd_en_o out 1  data-RAM read port
- rd_key_i / rd_value_i / rd_next_ptr_i / rd_next_val_i  in  KEY_WIDTH/VALUE_WIDTH/A_WIDTH/1  read word
- wr_addr_o, wr_key_o, wr_value_o, wr_next_ptr_o, wr_next_val_o, wr_en_o  out  data-RAM write port (same widths)
- head_wr_en_o out 1, head_wr_bucket_o out BUCKET_WIDTH, head_wr_ptr_o out A_WIDTH, head_wr_ptr_val_o out 1  head-table update
- free_ptr_o out A_WIDTH, free_ptr_en_o out 1  return slot to empty list
- res_key_o out KEY_WIDTH, res_code_o out 2 (0 SUCCESS, 1 NO_ENTRY, 2 CHAIN_ERR), res_count_o out CNT_W, res_valid_o out 1, res_ready_i in 1  result handshake

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, UNLINK, FREE, RESULT.
- IDLE: task_ready_o=1. When valid&ready, lock the command and clear count, hops and prev_val. If task_head_val_i=0, go to RESULT with NO_ENTRY. Otherwise set cur=head_ptr and go to RD_ISSUE.
- RD_ISSUE: rd_en_o=1 for exactly one cycle at rd_addr_o=cur, hops+1, then go to RD_WAIT.
- RD_WAIT: an internal RAM_LATENCY-deep valid pipe marks the data cycle. On that cycle, latch the word into cur_word.
  - If key matches, go to UNLINK.
  - If no match and next_val=1, set prev=cur, prev_word=word, prev_val=1, cur=next, then go to RD_ISSUE. If hops==MAX_CHAIN, go to RESULT with CHAIN_ERR instead.
  - If no match and next_val=0, go to RESULT: SUCCESS if count>0, else NO_ENTRY.
- UNLINK, one cycle:
  - If prev_val=0, pulse head_wr_en_o with bucket, ptr=cur_word.next_ptr, val=cur_word.next_val.
  - If prev_val=1, pulse wr_en_o at prev with prev_word, whose next fields are replaced by cur_word.next fields. prev_word is updated identically.
- FREE, one cycle: wr_en_o at cur with all fields zero; free_ptr_en_o with free_ptr_o=cur; count+1. Then:
  - If task_all=1 and cur_word.next_val=1: set cur=next and go to RD_ISSUE. prev is unchanged, because the predecessor stays the same. If hops==MAX_CHAIN, go to RESULT with CHAIN_ERR.
  - Otherwise go to RESULT with SUCCESS.
- RESULT: res_valid_o=1. Outputs hold stable until res_ready_i, then go to IDLE. res_count_o reports the number actually freed, including on CHAIN_ERR.
- Only one read is ever outstanding. No read and write overlap within a task.
- Key compare is an exact KEY_WIDTH equality.

## Timing
- While rst_n_i=0, all outputs are 0, including task_ready_o, and the state is IDLE. Ready rises on the first cycle after release.
- Accept at cycle T. Then rd_en_o at T+1 and data at T+1+RAM_LATENCY.
- Per non-matching node: 1+RAM_LATENCY cycles.
- Per matching node: 1+RAM_LATENCY+2 cycles.
- res_valid_o is asserted the cycle after the last node decision, or at T+1 for NO_ENTRY with no head.
- write, head and free strobes are single-cycle and never asserted in the same cycle as rd_en_o.
- Reset mid-task aborts immediately with no further strobes. RAM and head-table consistency is then the owner's responsibility.
- A back-to-back task is accepted the cycle after the result handshake.

## Test plan
- head_val=0, key 0x11 -> res_valid at T+1, code NO_ENTRY, count 0, no RAM/head/free strobes.
- Chain 5→9→3, keys A,B,C; delete B, mode one (RAM_LATENCY=2) -> write addr 5 next_ptr=3,val=1; zero write addr 9; free 9; SUCCESS, count 1.
- Same chain, delete A -> head write ptr 9 val 1; free 5; SUCCESS, count 1. Delete C -> write addr 9 next_val=0; free 3.
- Chain 4→7→2, keys K,X,K, task_all=1 -> head write ptr 7, free 4, write addr 7 next_val=0, free 2; SUCCESS, count 2.
- Cyclic chain 1→2→1, no match, MAX_CHAIN=4 -> exactly 4 reads, then CHAIN_ERR, count 0.
- res_ready_i held low for 10 cycles -> outputs stable, task_ready_o=0. Then assert rst_n_i low mid-walk -> all strobes 0 immediately, ready=1 after release.
